// File: rtl/booth_seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM encoding, iteration count and most-negative-operand constants.
package booth_seq_mult_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_e;

  localparam int unsigned ITER_COUNT  = 32;
  localparam logic [5:0]  LAST_STEP   = 6'(ITER_COUNT - 1);
  localparam logic [31:0] MOST_NEG    = 32'h8000_0000;
  localparam logic [63:0] MOST_NEG_SQ = 64'h4000_0000_0000_0000;

  // Booth recoding of the {Q[0], Q_1} pair.
  function automatic booth_op_e booth_sel(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_mult_ctrl_booth_operation.sv
// One combinational radix-2 Booth step: add/subtract M into A as selected
// by {Q[0],Q_1}, then arithmetic right shift of {A,Q,Q_1}.
module booth_operation
  import booth_seq_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic             q_1_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] q_out,
  output logic             q_1_out
);

  logic [WIDTH-1:0] sum;

  always_comb begin
    sum = a_in;
    case (booth_sel(q_in[0], q_1_in))
      OP_ADD:  sum = a_in + m_in;
      OP_SUB:  sum = a_in + ~m_in + WIDTH'(1);
      default: sum = a_in;
    endcase
    a_out   = {sum[WIDTH-1], sum[WIDTH-1:1]};
    q_out   = {sum[0], q_in[WIDTH-1:1]};
    q_1_out = q_in[0];
  end

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential signed 32x32 Booth multiplier controller with valid/ready
// handshakes on both the operand and product sides.
module booth_seq_mult_ctrl
  import booth_seq_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               q_1_q, q_1_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               both_min_q, both_min_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   step_a, step_q;
  logic               step_q_1;
  logic               m_is_min, q_is_min;

  assign m_is_min = (multiplicand == MOST_NEG);
  assign q_is_min = (multiplier == MOST_NEG);

  booth_operation #(.WIDTH(WIDTH)) u_step (
    .a_in    (a_q),
    .q_in    (q_q),
    .q_1_in  (q_1_q),
    .m_in    (m_q),
    .a_out   (step_a),
    .q_out   (step_q),
    .q_1_out (step_q_1)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    q_1_d       = q_1_q;
    cnt_d       = cnt_q;
    both_min_d  = both_min_q;
    product_d   = product_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          // Subtracting a most-negative M overflows A, so it is moved into
          // the multiplier slot; the both-most-negative case is forced later.
          if (m_is_min && !q_is_min) begin
            m_d = multiplier;
            q_d = multiplicand;
          end else begin
            m_d = multiplicand;
            q_d = multiplier;
          end
          a_d        = '0;
          q_1_d      = 1'b0;
          cnt_d      = '0;
          both_min_d = m_is_min && q_is_min;
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_RUN: begin
        a_d   = step_a;
        q_d   = step_q;
        q_1_d = step_q_1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: begin
        // First DONE cycle captures the result; out_valid follows one edge later.
        if (!out_valid_q) begin
          product_d   = both_min_q ? MOST_NEG_SQ : {a_q, q_q};
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      q_1_q       <= 1'b0;
      cnt_q       <= '0;
      both_min_q  <= 1'b0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      q_1_q       <= q_1_d;
      cnt_q       <= cnt_d;
      both_min_q  <= both_min_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Scoreboard bench for booth_seq_mult_ctrl: directed corner cases, reset
// abort, and random back-to-back traffic with consumer stalls.
module tb_booth_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int unsigned errs   = 0;
  int unsigned checks = 0;
  logic [63:0] exp_q[$];

  booth_seq_mult_ctrl #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] q);
    longint sm;
    longint sq;
    sm = $signed(m);
    sq = $signed(q);
    return 64'(sm * sq);
  endfunction

  // Offer one operand pair and hold it until accepted; expected value is
  // queued just before the accepting edge.
  task automatic send(input logic [31:0] m, input logic [31:0] q);
    int n;
    @(negedge clk);
    in_valid     = 1'b1;
    multiplicand = m;
    multiplier   = q;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(ref_prod(m, q));
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
    end
  endtask

  task automatic receive(input int unsigned ready_pct, input int unsigned limit);
    int unsigned n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_empty", 64'd1, 64'd0);
        else check("product", product, exp_q.pop_front());
        got = 1'b1;
      end
      n++;
    end
    if (!got) check("recv_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc;
    int unsigned ov_seen;
    logic [31:0] rm, rq;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 7 x -3 with latency measurement and a long consumer stall.
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    multiplicand = 32'd7;
    multiplier   = 32'hFFFF_FFFD;
    in_valid     = 1'b1;
    exp_q.push_back(ref_prod(32'd7, 32'hFFFF_FFFD));
    @(posedge clk);
    #1;
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h0BAD_F00D;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        check("run_busy", busy, 1);
        check("run_in_ready", in_ready, 0);
      end
      if (cyc == 20) check("run_no_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    check("latency", cyc, 33);
    check("done_busy", busy, 0);
    check("done_in_ready", in_ready, 0);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_product", product, 64'hFFFF_FFFF_FFFF_FFEB);
      check("stall_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    check("done_in_ready_hs", in_ready, 0);
    check("product", product, exp_q.pop_front());
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);

    // Most-negative operand corner cases.
    send(32'h8000_0000, 32'd5);
    receive(100, 200);
    send(32'h8000_0000, 32'h8000_0000);
    receive(100, 200);
    send(32'd5, 32'h8000_0000);
    receive(100, 200);

    // Reset in the middle of RUN aborts the operation.
    send(32'd123, 32'd456);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("mid_run_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("abort_no_valid", ov_seen, 0);

    // Random back-to-back traffic with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          rm = $urandom;
          rq = $urandom;
          if (i == 3)  rm = 32'h8000_0000;
          if (i == 7)  begin rm = 32'h8000_0000; rq = 32'h8000_0000; end
          if (i == 11) rq = 32'h8000_0000;
          if (i == 13) rq = 32'hFFFF_FFFF;
          if (i == 15) rm = 32'h0;
          send(rm, rq);
        end
      end
      begin
        for (int j = 0; j < 20; j++) receive(60, 400);
      end
    join

    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
